// File: rtl/sdpram_pkg.sv
// Shared types and limits for the pipelined simple-dual-port RAM.
// Holds the controller state enum and the maximum supported read latency.
// No logic; imported by sdpram_pipe and sdpram_rd_pipe.
package sdpram_pkg;

  // INIT: clearing rows one per cycle; READY: normal read/write service.
  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_e;

  localparam int RD_LAT_MAX = 4;

endpackage

// File: rtl/sdpram_rd_pipe.sv
// Valid/data delay line carrying read results from the array to the outputs.
// Latency: LAT cycles from vld_i/dat_i to vld_o/dat_o.
// Backpressure: none; accepts one entry per cycle. The output data holds while vld_o is low.
//
// Ports:
//   clk_i   - clock, rising edge
//   rst_ni  - asynchronous active-low reset, clears all stages
//   vld_i   - entry valid at the pipe input
//   dat_i   - entry data at the pipe input
//   vld_o   - entry valid at the pipe output
//   dat_o   - entry data at the pipe output (last valid value held)
module sdpram_rd_pipe
  import sdpram_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int LAT   = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             vld_i,
  input  logic [WIDTH-1:0] dat_i,
  output logic             vld_o,
  output logic [WIDTH-1:0] dat_o
);

  logic [LAT-1:0]            vld_q;
  logic [LAT-1:0][WIDTH-1:0] dat_q;

  // Each data stage only loads when the entry entering it is valid. This
  // makes the last stage hold its previous value during idle cycles and
  // keeps the intermediate stages from toggling on bubbles.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q <= '0;
      dat_q <= '0;
    end else begin
      vld_q[0] <= vld_i;
      if (vld_i) begin
        dat_q[0] <= dat_i;
      end
      for (int k = 1; k < LAT; k++) begin
        vld_q[k] <= vld_q[k-1];
        if (vld_q[k-1]) begin
          dat_q[k] <= dat_q[k-1];
        end
      end
    end
  end

  assign vld_o = vld_q[LAT-1];
  assign dat_o = dat_q[LAT-1];

endmodule

// File: rtl/sdpram_pipe.sv
// Simple dual-port RAM with byte-lane write strobes, a self-clearing INIT sweep and a pipelined read.
// Latency: reads return RD_LAT cycles after REN; writes are visible to reads issued the next cycle.
// Backpressure: none; one write and one read accepted per cycle once INIT_DONE is high.
//
// Optional feature macro: SDPRAM_PIPE_RDFWD_EN -- when defined, a read and write of the
// same row in the same cycle returns the merged row (strobed lanes from WDATA); otherwise
// the read returns the row contents from before the write.
//
// Ports:
//   CLK       - clock, rising edge
//   RSTN      - asynchronous active-low reset (does not touch the array itself)
//   WEN       - write enable
//   WADDR     - write row address; rows >= DEPTH are dropped
//   WDATA     - write data
//   WSTRB     - per-lane write strobe, one bit per BYTE_W bits of WDATA
//   REN       - read request
//   RADDR     - read row address; rows >= DEPTH read as zero
//   RVALID    - one pulse per accepted read, RD_LAT cycles after REN
//   RDATA     - read data, holds its last valid value while RVALID is low
//   INIT_DONE - high once every row has been cleared after reset
module sdpram_pipe
  import sdpram_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int DEPTH  = 512,
  parameter int BYTE_W = 8,
  parameter int RD_LAT = 2
) (
  input  logic                       CLK,
  input  logic                       RSTN,
  input  logic                       WEN,
  input  logic [$clog2(DEPTH)-1:0]   WADDR,
  input  logic [WIDTH-1:0]           WDATA,
  input  logic [WIDTH/BYTE_W-1:0]    WSTRB,
  input  logic                       REN,
  input  logic [$clog2(DEPTH)-1:0]   RADDR,
  output logic                       RVALID,
  output logic [WIDTH-1:0]           RDATA,
  output logic                       INIT_DONE
);

  localparam int AW    = $clog2(DEPTH);
  localparam int NLANE = WIDTH / BYTE_W;

  if ((WIDTH % BYTE_W) != 0) begin : g_bad_width
    $error("sdpram_pipe: WIDTH must be a multiple of BYTE_W");
  end
  if ((RD_LAT < 1) || (RD_LAT > RD_LAT_MAX)) begin : g_bad_lat
    $error("sdpram_pipe: RD_LAT must be in 1..RD_LAT_MAX");
  end

  // ---------------------------------------------------------------- control
  state_e         state_q, state_d;
  logic [AW-1:0]  init_cnt_q, init_cnt_d;
  logic           ready;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    case (state_q)
      INIT: begin
        if (int'(init_cnt_q) == DEPTH - 1) begin
          state_d = READY;
        end else begin
          init_cnt_d = init_cnt_q + AW'(1);
        end
      end
      READY:   state_d = READY;
      default: state_d = INIT;
    endcase
  end

  assign ready     = (state_q == READY);
  assign INIT_DONE = ready;

  // ---------------------------------------------------------------- array
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             init_wr;
  logic             wr_ok;
  logic             rd_in_range;
  logic [WIDTH-1:0] wr_old;
  logic [WIDTH-1:0] wr_row;
  logic             rd_vld;
  logic [WIDTH-1:0] rd_dat;

  // The sweep is held off while RSTN is low so that reset itself never
  // alters the array; clearing starts on the first edge after release.
  assign init_wr     = (state_q == INIT) && RSTN;
  assign wr_ok       = ready && WEN && (int'(WADDR) < DEPTH);
  assign rd_in_range = int'(RADDR) < DEPTH;

  // Strobed row: the new contents of WADDR after this cycle's write.
  always_comb begin
    wr_old = mem_q[WADDR];
    wr_row = wr_old;
    for (int i = 0; i < NLANE; i++) begin
      if (WSTRB[i]) begin
        wr_row[i*BYTE_W +: BYTE_W] = WDATA[i*BYTE_W +: BYTE_W];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (init_wr) begin
      mem_q[init_cnt_q] <= '0;
    end else if (wr_ok) begin
      mem_q[WADDR] <= wr_row;
    end
  end

  // ---------------------------------------------------------------- read
  assign rd_vld = ready && REN;

  always_comb begin
    rd_dat = '0;
    if (rd_in_range) begin
      rd_dat = mem_q[RADDR];
`ifdef SDPRAM_PIPE_RDFWD_EN
      if (wr_ok && (WADDR == RADDR)) begin
        rd_dat = wr_row;
      end
`endif
    end
  end

  // The first pipe stage is the array read register; the rest is delay.
  sdpram_rd_pipe #(
    .WIDTH (WIDTH),
    .LAT   (RD_LAT)
  ) u_rd_pipe (
    .clk_i  (CLK),
    .rst_ni (RSTN),
    .vld_i  (rd_vld),
    .dat_i  (rd_dat),
    .vld_o  (RVALID),
    .dat_o  (RDATA)
  );

endmodule

// File: tb/tb_sdpram_pipe.sv
// Self-checking bench for sdpram_pipe (WIDTH=32, DEPTH=16, BYTE_W=8, RD_LAT=2),
// plus a DEPTH=12 instance for out-of-range accesses.
// Reference model: a plain row array with a queue of expected read results.
module tb_sdpram_pipe;

  localparam int W   = 32;
  localparam int D   = 16;
  localparam int BW  = 8;
  localparam int LAT = 2;
  localparam int NL  = W / BW;
  localparam int D2  = 12;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic          RSTN;
  logic          wen, ren;
  logic [3:0]    waddr, raddr;
  logic [W-1:0]  wdata;
  logic [NL-1:0] wstrb;
  logic          rvalid, init_done;
  logic [W-1:0]  rdata;

  logic          wen2, ren2;
  logic [3:0]    waddr2, raddr2;
  logic [W-1:0]  wdata2;
  logic [NL-1:0] wstrb2;
  logic          rvalid2, init_done2;
  logic [W-1:0]  rdata2;

  sdpram_pipe #(.WIDTH(W), .DEPTH(D), .BYTE_W(BW), .RD_LAT(LAT)) u_dut (
    .CLK(CLK), .RSTN(RSTN), .WEN(wen), .WADDR(waddr), .WDATA(wdata), .WSTRB(wstrb),
    .REN(ren), .RADDR(raddr), .RVALID(rvalid), .RDATA(rdata), .INIT_DONE(init_done)
  );

  sdpram_pipe #(.WIDTH(W), .DEPTH(D2), .BYTE_W(BW), .RD_LAT(LAT)) u_dut12 (
    .CLK(CLK), .RSTN(RSTN), .WEN(wen2), .WADDR(waddr2), .WDATA(wdata2), .WSTRB(wstrb2),
    .REN(ren2), .RADDR(raddr2), .RVALID(rvalid2), .RDATA(rdata2), .INIT_DONE(init_done2)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // ------------------------------------------------------------ model
  typedef struct {
    int           due;
    logic [W-1:0] d;
  } rd_t;

  logic [W-1:0] m_mem [D];
  logic [W-1:0] m2 [D2];
  rd_t          rq[$];
  logic [W-1:0] m_last = '0;
  int           edges  = 0;
  bit           in_rst = 1'b0;

  function automatic logic [W-1:0] merge(input logic [W-1:0] o, input logic [W-1:0] n,
                                         input logic [NL-1:0] s);
    logic [W-1:0] r;
    r = o;
    for (int i = 0; i < NL; i++) if (s[i]) r[i*BW +: BW] = n[i*BW +: BW];
    return r;
  endfunction

  // One clock: update the model from the inputs sampled at the rising edge,
  // then compare all main-DUT outputs on the falling edge.
  task automatic tick();
    logic [W-1:0] rv;
    bit           ev;
    @(posedge CLK);
    if (!in_rst) begin
      edges++;
      if (edges <= D) begin
        m_mem[edges-1] = '0;
      end else begin
        if (ren) begin
          rv = m_mem[raddr];
`ifdef SDPRAM_PIPE_RDFWD_EN
          if (wen && waddr == raddr) rv = merge(rv, wdata, wstrb);
`endif
          rq.push_back(rd_t'{due: edges + LAT - 1, d: rv});
        end
        if (wen) m_mem[waddr] = merge(m_mem[waddr], wdata, wstrb);
      end
    end
    @(negedge CLK);
    ev = 1'b0;
    if (!in_rst && rq.size() > 0 && rq[0].due == edges) begin
      ev     = 1'b1;
      m_last = rq[0].d;
      void'(rq.pop_front());
    end
    chk("rvalid", {31'b0, rvalid}, {31'b0, ev});
    chk("rdata", rdata, m_last);
    chk("init_done", {31'b0, init_done}, {31'b0, (!in_rst && edges >= D)});
  endtask

  task automatic idle();
    wen = 1'b0; ren = 1'b0; waddr = '0; raddr = '0; wdata = '0; wstrb = '0;
  endtask

  task automatic do_reset(input int n);
    RSTN   = 1'b0;
    in_rst = 1'b1;
    #1;
    chk("rst_rvalid", {31'b0, rvalid}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_init_done", {31'b0, init_done}, 32'd0);
    chk("rst_rvalid12", {31'b0, rvalid2}, 32'd0);
    rq.delete();
    m_last = '0;
    edges  = 0;
    repeat (n) tick();
    RSTN   = 1'b1;
    in_rst = 1'b0;
  endtask

  task automatic rand_phase(input int n);
    for (int i = 0; i < n; i++) begin
      wen   = 1'($urandom_range(0, 1));
      waddr = 4'($urandom_range(0, 7));
      wdata = $urandom;
      wstrb = 4'($urandom_range(0, 15));
      ren   = 1'($urandom_range(0, 1));
      raddr = 4'($urandom_range(0, 7));
      tick();
    end
    idle();
  endtask

  task automatic rd2(input logic [3:0] a, input logic [W-1:0] e);
    ren2 = 1'b1; raddr2 = a;
    tick();
    ren2 = 1'b0;
    tick();
    chk("d12_rvalid", {31'b0, rvalid2}, 32'd1);
    chk("d12_rdata", rdata2, e);
  endtask

  initial begin
    idle();
    wen2 = 1'b0; ren2 = 1'b0; waddr2 = '0; raddr2 = '0; wdata2 = '0; wstrb2 = '0;
    RSTN = 1'b1;
    #2;
    do_reset(3);

    // INIT sweep: WEN/REN must be ignored, INIT_DONE rises after exactly 16 edges.
    for (int i = 0; i < D; i++) begin
      wen = 1'b1; waddr = 4'(i); wdata = $urandom; wstrb = 4'hF;
      ren = 1'b1; raddr = 4'(i);
      tick();
      if (i == D2 - 2) chk("d12_init_low", {31'b0, init_done2}, 32'd0);
      if (i == D2 - 1) chk("d12_init_high", {31'b0, init_done2}, 32'd1);
    end
    idle();

    // Strobed read-modify-write of row 3.
    wen = 1'b1; waddr = 4'd3; wdata = 32'hDEADBEEF; wstrb = 4'hF;
    tick();
    wdata = 32'h11223344; wstrb = 4'h5;
    tick();
    idle();
    ren = 1'b1; raddr = 4'd3;
    tick();
    idle();
    tick();
    chk("row3_vld", {31'b0, rvalid}, 32'd1);
    chk("row3_dat", rdata, 32'hDE22BE44);

    // Back-to-back reads of rows 0..3.
    for (int r = 0; r < 3; r++) begin
      wen = 1'b1; waddr = 4'(r); wdata = $urandom; wstrb = 4'hF;
      tick();
    end
    idle();
    for (int r = 0; r < 4; r++) begin
      ren = 1'b1; raddr = 4'(r);
      tick();
    end
    idle();
    repeat (3) tick();

    // Same-cycle write and read of row 5.
    wen = 1'b1; waddr = 4'd5; wdata = 32'h12345678; wstrb = 4'hF;
    tick();
    wdata = 32'hAAAAAAAA; wstrb = 4'h3; ren = 1'b1; raddr = 4'd5;
    tick();
    idle();
    tick();
`ifdef SDPRAM_PIPE_RDFWD_EN
    chk("same_row", rdata, 32'h1234AAAA);
`else
    chk("same_row", rdata, 32'h12345678);
`endif

    rand_phase(400);
    repeat (3) tick();

    // Reset with two reads in flight.
    wen = 1'b1; waddr = 4'd6; wdata = 32'hCAFEF00D; wstrb = 4'hF;
    tick();
    waddr = 4'd7; wdata = 32'h0BADC0DE;
    tick();
    idle();
    ren = 1'b1; raddr = 4'd6;
    tick();
    raddr = 4'd7;
    tick();
    idle();
    do_reset(2);
    repeat (D + 2) tick();

    rand_phase(200);
    repeat (3) tick();

    // DEPTH=12 instance: out-of-range write dropped, out-of-range read returns zero.
    for (int r = 0; r < D2; r++) begin
      wen2 = 1'b1; waddr2 = 4'(r); wdata2 = $urandom | 32'h1; wstrb2 = 4'hF;
      m2[r] = wdata2;
      tick();
    end
    waddr2 = 4'd13; wdata2 = 32'hFFFFFFFF;
    tick();
    wen2 = 1'b0;
    rd2(4'd0, m2[0]);
    rd2(4'd13, 32'd0);
    for (int r = 1; r < D2; r++) rd2(4'(r), m2[r]);

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
